// File: rtl/dp_ram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM between NUM_REQ requesters, with read-data return routing.
// Optional DP_RAM_ARB_CONFLICT_CNT_EN adds a saturating same-address write collision counter.

module dp_ram_port_arbiter_ret #(
    parameter int LAT   = 1,
    parameter int IDX_W = 2
) (
    input  logic             Clk_CI,
    input  logic             Rst_RBI,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    output logic             ret_vld,
    output logic [IDX_W-1:0] ret_idx
);
    logic [LAT:1]            vld_pipe;
    logic [LAT:1][IDX_W-1:0] idx_pipe;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
        end else begin
            vld_pipe[1] <= load;
            idx_pipe[1] <= load_idx;
            for (int s = 2; s <= LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                idx_pipe[s] <= idx_pipe[s-1];
            end
        end
    end

    assign ret_vld = vld_pipe[LAT];
    assign ret_idx = idx_pipe[LAT];
endmodule

module dp_ram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_REGS   = 0
) (
    input  logic                          Clk_CI,
    input  logic                          Rst_RBI,
    input  logic [NUM_REQ-1:0]            Req_SI,
    output logic [NUM_REQ-1:0]            Gnt_SO,
    input  logic [NUM_REQ-1:0]            We_SI,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] Addr_DI,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] WData_DI,
    output logic [NUM_REQ-1:0]            RValid_SO,
    output logic [NUM_REQ*DATA_WIDTH-1:0] RData_DO,
    output logic                          CSelA_SO,
    output logic                          WrEnA_SO,
    output logic [ADDR_WIDTH-1:0]         AddrA_DO,
    output logic [DATA_WIDTH-1:0]         WrDataA_DO,
    input  logic [DATA_WIDTH-1:0]         RdDataA_DI,
    output logic                          CSelB_SO,
    output logic                          WrEnB_SO,
    output logic [ADDR_WIDTH-1:0]         AddrB_DO,
    output logic [DATA_WIDTH-1:0]         WrDataB_DO,
    input  logic [DATA_WIDTH-1:0]         RdDataB_DI,
    output logic [15:0]                   ConflictCnt_DO
);
    localparam int LAT   = 1 + ((OUT_REGS > 0) ? 1 : 0);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rdata;
    logic [IDX_W-1:0] rr_ptr_q, win_a, win_b, last_gnt, scan_idx;
    logic             vld_a, vld_b_raw, vld_b, collide;
    int               scan_j;

    assign addr     = Addr_DI;
    assign wdata    = WData_DI;
    assign RData_DO = rdata;

    // Circular scan from the pointer: first hit goes to port A, second to port B.
    always_comb begin
        win_a     = '0;
        win_b     = '0;
        vld_a     = 1'b0;
        vld_b_raw = 1'b0;
        scan_j    = 0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_j = int'(rr_ptr_q) + k;
            if (scan_j >= NUM_REQ) scan_j = scan_j - NUM_REQ;
            scan_idx = IDX_W'(scan_j);
            if (Req_SI[scan_idx]) begin
                if (!vld_a) begin
                    vld_a = 1'b1;
                    win_a = scan_idx;
                end else if (!vld_b_raw) begin
                    vld_b_raw = 1'b1;
                    win_b     = scan_idx;
                end
            end
        end
    end

    assign collide  = vld_a & vld_b_raw & We_SI[win_a] & We_SI[win_b] & (addr[win_a] == addr[win_b]);
    assign vld_b    = vld_b_raw & ~collide;
    assign last_gnt = vld_b ? win_b : win_a;

    always_comb begin
        Gnt_SO = '0;
        if (vld_a) Gnt_SO[win_a] = 1'b1;
        if (vld_b) Gnt_SO[win_b] = 1'b1;
    end

    assign CSelA_SO   = vld_a;
    assign WrEnA_SO   = vld_a & We_SI[win_a];
    assign AddrA_DO   = vld_a ? addr[win_a] : '0;
    assign WrDataA_DO = vld_a ? wdata[win_a] : '0;
    assign CSelB_SO   = vld_b;
    assign WrEnB_SO   = vld_b & We_SI[win_b];
    assign AddrB_DO   = vld_b ? addr[win_b] : '0;
    assign WrDataB_DO = vld_b ? wdata[win_b] : '0;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI)   rr_ptr_q <= '0;
        else if (vld_a) rr_ptr_q <= (last_gnt == IDX_W'(NUM_REQ-1)) ? '0 : last_gnt + 1'b1;
    end

    logic [1:0]                  ret_load, ret_vld;
    logic [1:0][IDX_W-1:0]       ret_load_idx, ret_idx;
    logic [1:0][DATA_WIDTH-1:0]  port_rd;

    assign ret_load     = {vld_b & ~We_SI[win_b], vld_a & ~We_SI[win_a]};
    assign ret_load_idx = {win_b, win_a};
    assign port_rd      = {RdDataB_DI, RdDataA_DI};

    dp_ram_port_arbiter_ret #(.LAT(LAT), .IDX_W(IDX_W)) u_ret [1:0] (
        .Clk_CI   (Clk_CI),
        .Rst_RBI  (Rst_RBI),
        .load     (ret_load),
        .load_idx (ret_load_idx),
        .ret_vld  (ret_vld),
        .ret_idx  (ret_idx)
    );

    // A requester is granted at most once per cycle, so the two ports never collide here.
    always_comb begin
        RValid_SO = '0;
        rdata     = '0;
        for (int p = 0; p < 2; p++) begin
            if (ret_vld[p]) begin
                RValid_SO[ret_idx[p]] = 1'b1;
                rdata[ret_idx[p]]     = port_rd[p];
            end
        end
    end

`ifdef DP_RAM_ARB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt_q;
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI)                                conflict_cnt_q <= '0;
        else if (collide && conflict_cnt_q != 16'hFFFF) conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
    assign ConflictCnt_DO = conflict_cnt_q;
`else
    assign ConflictCnt_DO = '0;
`endif
endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// Directed + randomized bench for dp_ram_port_arbiter against a queue-based reference model and a behavioural RAM.
module tb_dp_ram_port_arbiter;
    parameter int OUT_REGS = 0;
    localparam int N = 4, AW = 10, DW = 32;
    localparam int LAT = 1 + ((OUT_REGS > 0) ? 1 : 0);

    logic              Clk_CI = 0, Rst_RBI = 0;
    logic [N-1:0]      Req_SI = '0, We_SI = '0, Gnt_SO, RValid_SO;
    logic [N*AW-1:0]   Addr_DI = '0;
    logic [N*DW-1:0]   WData_DI = '0, RData_DO;
    logic              CSelA_SO, WrEnA_SO, CSelB_SO, WrEnB_SO;
    logic [AW-1:0]     AddrA_DO, AddrB_DO;
    logic [DW-1:0]     WrDataA_DO, WrDataB_DO, RdDataA_DI, RdDataB_DI;
    logic [15:0]       ConflictCnt_DO;

    dp_ram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REGS(OUT_REGS)) dut (
        .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .Req_SI(Req_SI), .Gnt_SO(Gnt_SO), .We_SI(We_SI),
        .Addr_DI(Addr_DI), .WData_DI(WData_DI), .RValid_SO(RValid_SO), .RData_DO(RData_DO),
        .CSelA_SO(CSelA_SO), .WrEnA_SO(WrEnA_SO), .AddrA_DO(AddrA_DO), .WrDataA_DO(WrDataA_DO),
        .RdDataA_DI(RdDataA_DI), .CSelB_SO(CSelB_SO), .WrEnB_SO(WrEnB_SO), .AddrB_DO(AddrB_DO),
        .WrDataB_DO(WrDataB_DO), .RdDataB_DI(RdDataB_DI), .ConflictCnt_DO(ConflictCnt_DO)
    );

    always #5 Clk_CI = ~Clk_CI;

    function automatic logic [DW-1:0] init_val(int a);
        return DW'(a * 32'h9E3779B1 + 32'h1234);
    endfunction

    // Behavioural read-before-write dual-port RAM with optional output register.
    logic [DW-1:0] ram [1 << AW];
    logic [DW-1:0] rd_a0, rd_b0, rd_a1, rd_b1;
    initial for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(i);
    always @(posedge Clk_CI) begin
        if (CSelA_SO) begin
            if (WrEnA_SO) ram[AddrA_DO] <= WrDataA_DO;
            else          rd_a0 <= ram[AddrA_DO];
        end
        if (CSelB_SO) begin
            if (WrEnB_SO) ram[AddrB_DO] <= WrDataB_DO;
            else          rd_b0 <= ram[AddrB_DO];
        end
        rd_a1 <= rd_a0;
        rd_b1 <= rd_b0;
    end
    assign RdDataA_DI = (OUT_REGS > 0) ? rd_a1 : rd_a0;
    assign RdDataB_DI = (OUT_REGS > 0) ? rd_b1 : rd_b0;

    // Reference model state
    typedef struct { int due; int req; logic [DW-1:0] data; } ret_t;
    ret_t          ret_q[$];
    logic [DW-1:0] mem_m [1 << AW];
    int            ptr_m, coll_m, cyc;
    logic [N-1:0]  gnt_exp;
    logic [DW-1:0] last_rd [N];
    int            errors = 0, checks = 0;

    logic [N-1:0]          req_v = '0, we_v = '0;
    logic [N-1:0][AW-1:0]  addr_v = '0;
    logic [N-1:0][DW-1:0]  wd_v = '0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt_exp();
`ifdef DP_RAM_ARB_CONFLICT_CNT_EN
        return coll_m;
`else
        return 0;
`endif
    endfunction

    task automatic check_returns();
        logic [N-1:0] erv;
        logic [DW-1:0] erd [N];
        erv = '0;
        for (int i = 0; i < N; i++) erd[i] = '0;
        for (int j = ret_q.size() - 1; j >= 0; j--)
            if (ret_q[j].due == cyc) begin
                erv[ret_q[j].req] = 1'b1;
                erd[ret_q[j].req] = ret_q[j].data;
                ret_q.delete(j);
            end
        chk("rvalid", 64'(RValid_SO), 64'(erv));
        for (int i = 0; i < N; i++)
            if (erv[i]) begin
                chk($sformatf("rdata%0d", i), 64'(RData_DO[i*DW +: DW]), 64'(erd[i]));
                last_rd[i] = RData_DO[i*DW +: DW];
            end
        chk("conflict_cnt", 64'(ConflictCnt_DO), 64'(cnt_exp()));
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step();
        int q[$];
        int ga, gb, last;
        @(negedge Clk_CI);
        Req_SI = req_v; We_SI = we_v; Addr_DI = addr_v; WData_DI = wd_v;
        #1;
        check_returns();
        for (int k = 0; k < N; k++) if (req_v[(ptr_m + k) % N]) q.push_back((ptr_m + k) % N);
        ga = (q.size() > 0) ? q[0] : -1;
        gb = (q.size() > 1) ? q[1] : -1;
        if (gb >= 0 && we_v[ga] && we_v[gb] && addr_v[ga] == addr_v[gb]) begin
            gb = -1;
            if (coll_m < 16'hFFFF) coll_m++;
        end
        gnt_exp = '0;
        if (ga >= 0) gnt_exp[ga] = 1'b1;
        if (gb >= 0) gnt_exp[gb] = 1'b1;
        chk("gnt", 64'(Gnt_SO), 64'(gnt_exp));
        chk("csel_a", 64'(CSelA_SO), 64'(ga >= 0));
        chk("wren_a", 64'(WrEnA_SO), 64'(ga >= 0 && we_v[ga]));
        chk("addr_a", 64'(AddrA_DO), (ga >= 0) ? 64'(addr_v[ga]) : 64'd0);
        if (ga >= 0 && we_v[ga]) chk("wdata_a", 64'(WrDataA_DO), 64'(wd_v[ga]));
        chk("csel_b", 64'(CSelB_SO), 64'(gb >= 0));
        chk("wren_b", 64'(WrEnB_SO), 64'(gb >= 0 && we_v[gb]));
        chk("addr_b", 64'(AddrB_DO), (gb >= 0) ? 64'(addr_v[gb]) : 64'd0);
        if (gb >= 0 && we_v[gb]) chk("wdata_b", 64'(WrDataB_DO), 64'(wd_v[gb]));
        // Reads capture old contents before this cycle's writes land.
        if (ga >= 0 && !we_v[ga]) ret_q.push_back('{cyc + LAT, ga, mem_m[addr_v[ga]]});
        if (gb >= 0 && !we_v[gb]) ret_q.push_back('{cyc + LAT, gb, mem_m[addr_v[gb]]});
        if (ga >= 0 && we_v[ga]) mem_m[addr_v[ga]] = wd_v[ga];
        if (gb >= 0 && we_v[gb]) mem_m[addr_v[gb]] = wd_v[gb];
        last = (gb >= 0) ? gb : ga;
        if (last >= 0) ptr_m = (last + 1) % N;
        cyc++;
    endtask

    task automatic do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk_CI);
            Rst_RBI = 0; req_v = '0; Req_SI = '0;
            #1;
            ret_q.delete(); ptr_m = 0; coll_m = 0;
            chk("rst_rvalid", 64'(RValid_SO), 64'd0);
            chk("rst_gnt", 64'(Gnt_SO), 64'd0);
            chk("rst_csel", 64'({CSelA_SO, CSelB_SO}), 64'd0);
            chk("rst_cnt", 64'(ConflictCnt_DO), 64'd0);
            cyc++;
        end
        Rst_RBI = 1;
    endtask

    task automatic set_req(int i, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        req_v[i] = 1'b1; we_v[i] = we; addr_v[i] = a; wd_v[i] = d;
    endtask

    task automatic idle(int n);
        req_v = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem_m[i] = init_val(i);
        for (int i = 0; i < N; i++) last_rd[i] = '0;
        cyc = 0; ptr_m = 0; coll_m = 0;
        do_reset();
        idle(1);

        // Single-requester write then read-back
        set_req(0, 1, 10'h010, 32'hDEADBEEF); step();
        set_req(0, 0, 10'h010, 32'h0); step();
        idle(LAT + 1);
        chk("t1_readback", 64'(last_rd[0]), 64'hDEADBEEF);

        // All four reading for four cycles from pointer 0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) set_req(i, 0, AW'(10'h020 + i + 4 * k), 32'h0);
            step();
        end
        idle(LAT + 1);

        // Same-address write collision between requesters 1 and 2
        set_req(1, 1, 10'h3FF, 32'h11); set_req(2, 1, 10'h3FF, 32'h22); step();
        req_v[1] = 1'b0; step();
        req_v = '0; set_req(0, 0, 10'h3FF, 32'h0); step();
        idle(LAT + 1);
        chk("t3_final_data", 64'(last_rd[0]), 64'h22);

        // Read and write of the same address in one cycle
        set_req(0, 1, 10'h005, 32'h55); step();
        req_v = '0; set_req(0, 1, 10'h005, 32'hAA); set_req(1, 0, 10'h005, 32'h0); step();
        idle(LAT + 1);
        chk("t4_old_data", 64'(last_rd[1]), 64'h55);
        set_req(2, 0, 10'h005, 32'h0); step();
        idle(LAT + 1);
        chk("t4_new_data", 64'(last_rd[2]), 64'hAA);

        // Back-to-back reads from requester 3
        for (int k = 0; k < 3; k++) begin
            req_v = '0; set_req(3, 0, AW'(10'h100 + k), 32'h0); step();
        end
        idle(LAT + 1);

        // Reset one cycle after two read grants
        req_v = '0; set_req(0, 0, 10'h030, 32'h0); set_req(1, 0, 10'h031, 32'h0); step();
        do_reset();
        idle(LAT + 2);
        set_req(1, 0, 10'h040, 32'h0); set_req(3, 0, 10'h041, 32'h0); step();
        idle(LAT + 1);

        // Randomized traffic with held requests and occasional withdrawals
        req_v = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] && ($urandom % 2 == 0))
                    set_req(i, 1'($urandom % 2), AW'($urandom_range(0, 7)), $urandom);
                else if (req_v[i] && ($urandom % 8 == 0))
                    req_v[i] = 1'b0;
            end
            step();
            req_v = req_v & ~gnt_exp;
        end
        idle(LAT + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dp_ram_port_arbiter.md
Name: dp_ram_port_arbiter

Overview:
Shares one synchronous dual-port RAM (ports A/B, 1-cycle read, optional output register stage) between NUM_REQ requesters.
- Each cycle, grants up to two requests in round-robin order: first winner on port A, second on port B.
- Resolves same-address write collisions.
- Routes returned read data back to the issuing requester with a per-requester valid strobe.
- Sits between requester-side interfaces (DMA, cores, config masters) and the RAM macro.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ADDR_WIDTH, 10, RAM address width
DATA_WIDTH, 32, RAM data width
OUT_REGS, 0, must equal the RAM's OUT_REGS; read latency LAT = 1 + (OUT_REGS>0)

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  async active-low reset
Req_SI  in  NUM_REQ  per-requester request
Gnt_SO  out  NUM_REQ  per-requester grant (combinational, same cycle)
We_SI  in  NUM_REQ  1=write, 0=read
Addr_DI  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
WData_DI  in  NUM_REQ*DATA_WIDTH  flattened write data
RValid_SO  out  NUM_REQ  read-data valid, one cycle per granted read
RData_DO  out  NUM_REQ*DATA_WIDTH  flattened read data, meaningful only while RValid_SO[i]
CSelA_SO, WrEnA_SO  out  1  RAM port A select / write enable
AddrA_DO  out  ADDR_WIDTH  RAM port A address
WrDataA_DO  out  DATA_WIDTH  RAM port A write data
RdDataA_DI  in  DATA_WIDTH  RAM port A read data
CSelB_SO, WrEnB_SO, AddrB_DO, WrDataB_DO, RdDataB_DI  same as port A, for port B
ConflictCnt_DO  out  16  same-address write collision count (see optional feature)

Behaviour:
Reset and clocking:
- Clk_CI rising edge; Rst_RBI asynchronous, active-low.
- Reset values: RrPtr_DP=0, all return-pipeline valids 0, RValid_SO=0, ConflictCnt=0.
- Gnt_SO and the RAM port outputs are combinational and are 0 whenever Req_SI=0.

Handshake:
- Requester holds Req/We/Addr/WData stable until Gnt in the same cycle.
- A request is transferred on Req&Gnt.
- Dropping Req before Gnt is allowed and is a no-op.

Arbitration (combinational, each cycle):
- Winner A = first i with Req_SI[i], scanning RrPtr..NUM_REQ-1 then 0..RrPtr-1.
- Winner B = next requester after A in the same circular scan.
- Write collision: both winners write and addresses are equal -> B's grant is suppressed; B stays pending; port B idle.
- Read/write to the same address on A and B is allowed; the read returns the old contents (RAM read-before-write).
- RAM drive: CSelX=1, WrEnX=We, AddrX/WrDataX from the winner; CSelX=0 when there is no winner.

Pointer update (registered):
- RrPtr <= (index of last granted requester + 1) mod NUM_REQ.
- Unchanged when nothing is granted.

Read return:
- Per port, a LAT-deep pipeline holds {valid, requester index}.
- A stage is loaded with valid only for granted reads; writes produce no RValid.
- When the stage-LAT entry is valid: RValid_SO[idx]=1 and RData_DO[idx] = RdDataX_DI of that port.
- A and B can return to different requesters in the same cycle.
- A requester can never receive two returns in one cycle, because it is granted at most once per cycle.
- Back-to-back grants to one requester yield back-to-back RValid pulses, in order.

Reset mid-operation:
- In-flight reads are discarded; no RValid after reset deasserts.
- Pending requests re-arbitrate from RrPtr=0.

Invariants:
- At most two grants per cycle.
- A grant implies Req.
- Gnt is one-hot-or-two-hot.

Optional Feature:
Macro DP_RAM_ARB_CONFLICT_CNT_EN.
- Defined: a 16-bit saturating counter increments on every cycle a write collision suppresses the B grant. It saturates at 0xFFFF, resets to 0, and drives ConflictCnt_DO.
- Undefined: no counter logic; ConflictCnt_DO tied to 0.

Test Plan:
1. Reset, then Req=4'b0001 write addr 0x010 data 0xDEADBEEF; next cycle read 0x010 -> Gnt[0] on port A in both cycles; RValid_SO[0] exactly LAT cycles after the read grant with RData 0xDEADBEEF.
2. Req=4'b1111, all reads, held for 4 cycles, RrPtr=0 -> grants (0,1),(2,3),(0,1),(2,3) on (A,B); each read returns to the correct requester after LAT cycles.
3. Req 1 and 2 both write addr 0x3FF (data 0x11/0x22), RrPtr=0 -> cycle 1: only Gnt[1]; cycle 2: Gnt[2]; final read of 0x3FF returns 0x22; ConflictCnt=1 with the macro, 0 without.
4. Req 0 writes 0x5 = 0xAA while req 1 reads 0x5 (old value 0x55), same cycle -> both granted; req 1 receives 0x55; a later read returns 0xAA.
5. OUT_REGS=1 build: reads from req 3 granted on 3 consecutive cycles -> RValid_SO[3] high for 3 consecutive cycles starting 2 cycles after the first grant, in order.
6. Assert Rst_RBI=0 one cycle after two read grants -> no RValid_SO pulses afterwards; RrPtr=0; arbitration resumes after reset release.
